alu_seq_exec: RTL and testbench

Multi-cycle execute stage directly downstream of the instruction control unit: consumes its `op_select`/`sub` decode plus two operands and produces a registered result with status flags. ADD, SUB, AND and OR complete in one cycle. MUL (shift-add) and DIV (restoring) iterate one bit per cycle under a start/busy/done handshake, so the sequencer can stall on long operations.

---
 rtl/alu_seq_exec.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq_exec.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute stage with single-cycle ADD/SUB/AND/OR and
// iterative shift-add MUL / restoring DIV under a start/busy/done handshake.
module alu_seq_exec #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_select,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic             isDiv_q, isDiv_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] resultHi_q, resultHi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             addSub;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divTrial;
  logic             divFits;
  logic [WIDTH-1:0] iterHi;
  logic [WIDTH-1:0] iterLo;
  logic [WIDTH-1:0] logicRes;

  // Registers for FSM state, iteration datapath and all visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      isDiv_q    <= 1'b0;
      operand_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      resultHi_q <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      isDiv_q    <= isDiv_d;
      operand_q  <= operand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      resultHi_q <= resultHi_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
    end
  end

  // Arithmetic helpers: the adder, and one MUL or DIV step on the held state.
  always_comb begin
    addSub   = sub && (op_select == 3'b000 || op_select == 3'b001);
    sum      = {1'b0, a} + {1'b0, b ^ {WIDTH{addSub}}} + {{WIDTH{1'b0}}, addSub};
    logicRes = (op_select == 3'b010) ? (a & b) : (a | b);
    // Multiplier step: conditionally add multiplicand to the upper half, then shift right.
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
    // Divider step: shift in next dividend bit, trial-subtract the divisor.
    divShift = {hi_q, lo_q[WIDTH-1]};
    divTrial = divShift - {1'b0, operand_q};
    divFits  = ~divTrial[WIDTH];
    if (isDiv_q) begin
      iterHi = divFits ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
      iterLo = {lo_q[WIDTH-2:0], divFits};
    end else begin
      iterHi = mulSum[WIDTH:1];
      iterLo = {mulSum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: accept new ops in IDLE, iterate and finish in RUN.
  always_comb begin
    state_d    = state_q;
    isDiv_d    = isDiv_q;
    operand_d  = operand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    resultHi_d = resultHi_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_select)
            3'b100: begin
              state_d   = RUN;
              isDiv_d   = 1'b0;
              operand_d = a;
              hi_d      = '0;
              lo_d      = b;
              cnt_d     = CW'(WIDTH);
            end
            3'b101: begin
              if (b == '0) begin
                result_d   = '1;
                resultHi_d = a;
                zero_d     = 1'b0;
                carry_d    = 1'b0;
                dbz_d      = 1'b1;
                done_d     = 1'b1;
              end else begin
                state_d   = RUN;
                isDiv_d   = 1'b1;
                operand_d = b;
                hi_d      = '0;
                lo_d      = a;
                cnt_d     = CW'(WIDTH);
              end
            end
            3'b010, 3'b011: begin
              result_d   = logicRes;
              resultHi_d = '0;
              zero_d     = (logicRes == '0);
              carry_d    = 1'b0;
              dbz_d      = 1'b0;
              done_d     = 1'b1;
            end
            default: begin
              result_d   = sum[WIDTH-1:0];
              resultHi_d = '0;
              zero_d     = (sum[WIDTH-1:0] == '0);
              carry_d    = sum[WIDTH];
              dbz_d      = 1'b0;
              done_d     = 1'b1;
            end
          endcase
        end
      end
      RUN: begin
        hi_d  = iterHi;
        lo_d  = iterLo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = IDLE;
          result_d   = iterLo;
          resultHi_d = iterHi;
          zero_d     = (iterLo == '0);
          carry_d    = 1'b0;
          dbz_d      = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign result      = result_q;
  assign result_hi   = resultHi_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed test of alu_seq_exec at WIDTH=8.
module tb_alu_seq_exec;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op_select = 3'b000;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, carry, div_by_zero;
  logic [W-1:0] result, result_hi;

  int checks = 0;
  int errors = 0;
  int busyCycles;

  alu_seq_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_select(op_select), .sub(sub),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .carry(carry), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Drive one request through its accepting edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] op, input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    op_select = op; sub = s; a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Step clocks while busy (bounded), counting cycles with busy high.
  task automatic runUntilIdle();
    for (int i = 0; i < 30 && busy; i++) begin
      @(posedge clk);
      #1;
      if (busy) busyCycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, result_hi, zero, carry, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b res=%h hi=%h z=%b c=%b dbz=%b expected all 0",
               busy, done, result, result_hi, zero, carry, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    issue(3'b000, 1'b0, 8'd200, 8'd100);
    checks++;
    if ({done, busy, result, carry, zero} !== {1'b1, 1'b0, 8'd44, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_200_100 got done=%b busy=%b res=%0d c=%b z=%b expected done=1 busy=0 res=44 c=1 z=0",
               done, busy, result, carry, zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL add_done_pulse got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_sub();
    issue(3'b001, 1'b1, 8'd5, 8'd7);
    checks++;
    if ({done, result, carry, zero, result_hi} !== {1'b1, 8'd254, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL sub_5_7 got done=%b res=%0d c=%b z=%b hi=%0d expected 1 254 0 0 0",
               done, result, carry, zero, result_hi);
    end
    issue(3'b001, 1'b1, 8'd7, 8'd7);
    checks++;
    if ({done, result, carry, zero} !== {1'b1, 8'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_7_7 got done=%b res=%0d c=%b z=%b expected 1 0 1 1", done, result, carry, zero);
    end
  endtask

  task automatic test_mul();
    issue(3'b100, 1'b0, 8'd25, 8'd13);
    busyCycles = busy ? 1 : 0;
    @(negedge clk);
    a = 8'd99; b = 8'd77; op_select = 3'b101;
    runUntilIdle();
    checks++;
    if (busyCycles !== W) begin
      errors++;
      $display("FAIL mul_busy_cycles got %0d expected %0d", busyCycles, W);
    end
    checks++;
    if ({done, result, result_hi, zero, carry} !== {1'b1, 8'h45, 8'h01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_25_13 got done=%b res=%h hi=%h z=%b c=%b expected 1 45 01 0 0",
               done, result, result_hi, zero, carry);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_pulse got done=%b expected 0", done);
    end
  endtask

  task automatic test_div();
    issue(3'b101, 1'b0, 8'd200, 8'd7);
    busyCycles = busy ? 1 : 0;
    runUntilIdle();
    checks++;
    if (busyCycles !== W) begin
      errors++;
      $display("FAIL div_busy_cycles got %0d expected %0d", busyCycles, W);
    end
    checks++;
    if ({done, result, result_hi, div_by_zero} !== {1'b1, 8'd28, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL div_200_7 got done=%b q=%0d r=%0d dbz=%b expected 1 28 4 0",
               done, result, result_hi, div_by_zero);
    end
  endtask

  task automatic test_div_zero();
    issue(3'b101, 1'b0, 8'd200, 8'd0);
    checks++;
    if ({done, busy, result, result_hi, div_by_zero, zero} !== {1'b1, 1'b0, 8'hFF, 8'd200, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL div_by_zero got done=%b busy=%b res=%h hi=%0d dbz=%b z=%b expected 1 0 ff 200 1 0",
               done, busy, result, result_hi, div_by_zero, zero);
    end
  endtask

  task automatic test_op110();
    issue(3'b110, 1'b1, 8'd1, 8'd2);
    checks++;
    if ({done, result, result_hi, div_by_zero, carry} !== {1'b1, 8'd3, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL op110_add got done=%b res=%0d hi=%0d dbz=%b c=%b expected 1 3 0 0 0",
               done, result, result_hi, div_by_zero, carry);
    end
  endtask

  task automatic test_back_to_back();
    issue(3'b100, 1'b0, 8'd3, 8'd5);
    busyCycles = busy ? 1 : 0;
    @(negedge clk);
    start = 1'b1; op_select = 3'b000; a = 8'd9; b = 8'd9;
    repeat (W - 2) begin
      @(posedge clk);
      #1;
      if (busy) busyCycles++;
    end
    start = 1'b0;
    runUntilIdle();
    checks++;
    if ({busyCycles, done, result, result_hi} !== {32'(W), 1'b1, 8'd15, 8'd0}) begin
      errors++;
      $display("FAIL start_held_mul got cycles=%0d done=%b res=%0d hi=%0d expected %0d 1 15 0",
               busyCycles, done, result, result_hi, W);
    end
    op_select = 3'b010; sub = 1'b0; a = 8'hF0; b = 8'h3C; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if ({done, busy, result, carry} !== {1'b1, 1'b0, 8'h30, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back_and got done=%b busy=%b res=%h c=%b expected 1 0 30 0",
               done, busy, result, carry);
    end
  endtask

  task automatic test_reset_mid_div();
    int doneSeen;
    issue(3'b101, 1'b0, 8'd200, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, result_hi, zero, carry, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid_div got busy=%b done=%b res=%h hi=%h z=%b c=%b dbz=%b expected all 0",
               busy, done, result, result_hi, zero, carry, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      errors++;
      $display("FAIL abandoned_op_done got %0d cycles with done/busy expected 0", doneSeen);
    end
    issue(3'b000, 1'b0, 8'd1, 8'd1);
    checks++;
    if ({done, result, busy} !== {1'b1, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL add_after_reset got done=%b res=%0d busy=%b expected 1 2 0", done, result, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_div_zero();
    test_op110();
    test_back_to_back();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
